// File: rtl/etapa_ex.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative shift-add
// multiplier and the EX/MEM pipeline register.
//
// Multiplier FSM
//   state   | meaning
//   IDLE    | no multiply pending; a MUL on the inputs starts one
//   BUSY    | one shift-add iteration per edge, stall upstream
//   DONE    | product ready, loaded into EX/MEM on the next edge
module etapa_ex (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic [31:0] i_immediate,
  input  logic [4:0]  i_shamt,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [3:0]  i_alu_ctrl,
  input  logic        i_alu_src,
  input  logic        i_reg_dst,
  input  logic [1:0]  i_fwd_a,
  input  logic [1:0]  i_fwd_b,
  input  logic [31:0] i_fwd_mem_data,
  input  logic [31:0] i_fwd_wb_data,
  input  logic        i_WB_write,
  input  logic        i_WB_mem_to_reg,
  input  logic        i_MEM_read,
  input  logic        i_MEM_write,
  input  logic        i_MEM_unsigned,
  input  logic [1:0]  i_MEM_byte_half_word,
  output logic [31:0] o_ALU_result,
  output logic [31:0] o_data_to_write_in_MEM,
  output logic [4:0]  o_write_reg,
  output logic        o_WB_write,
  output logic        o_WB_mem_to_reg,
  output logic        o_MEM_read,
  output logic        o_MEM_write,
  output logic        o_MEM_unsigned,
  output logic [1:0]  o_MEM_byte_half_word,
  output logic        o_busy
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLLV = 4'd11;
  localparam logic [3:0] OP_SRLV = 4'd12;
  localparam logic [3:0] OP_SRAV = 4'd13;
  localparam logic [3:0] OP_LUI  = 4'd14;
  localparam logic [3:0] OP_MUL  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  mul_state_t  state, state_next;
  logic        mul_start;

  logic [31:0] op_a, rt_fwd, op_b, alu_result;
  logic [4:0]  dest;
  logic [6:0]  in_ctl;

  logic [31:0] mul_mcand, mul_mplier, mul_prod, mul_rt;
  logic [4:0]  mul_dest;
  logic [6:0]  mul_ctl;
  logic [5:0]  iter_cnt;

  logic [31:0] ex_result, ex_data;
  logic [4:0]  ex_dest;
  logic [6:0]  ex_ctl;

  assign in_ctl = {i_WB_write, i_WB_mem_to_reg, i_MEM_read, i_MEM_write,
                   i_MEM_unsigned, i_MEM_byte_half_word};

  // Forwarding muxes and B-operand / destination selection
  always_comb begin
    case (i_fwd_a)
      2'b01:   op_a = i_fwd_mem_data;
      2'b10:   op_a = i_fwd_wb_data;
      default: op_a = i_rs_data;
    endcase
    case (i_fwd_b)
      2'b01:   rt_fwd = i_fwd_mem_data;
      2'b10:   rt_fwd = i_fwd_wb_data;
      default: rt_fwd = i_rt_data;
    endcase
    op_b = i_alu_src ? i_immediate : rt_fwd;
    dest = i_reg_dst ? i_rd : i_rt;
  end

  // Single-cycle ALU; MUL goes through the iterative datapath instead
  always_comb begin
    alu_result = '0;
    case (i_alu_ctrl)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_NOR:  alu_result = ~(op_a | op_b);
      OP_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_result = {31'd0, op_a < op_b};
      OP_SLL:  alu_result = op_b << i_shamt;
      OP_SRL:  alu_result = op_b >> i_shamt;
      OP_SRA:  alu_result = $unsigned($signed(op_b) >>> i_shamt);
      OP_SLLV: alu_result = op_b << op_a[4:0];
      OP_SRLV: alu_result = op_b >> op_a[4:0];
      OP_SRAV: alu_result = $unsigned($signed(op_b) >>> op_a[4:0]);
      OP_LUI:  alu_result = {op_b[15:0], 16'd0};
      default: alu_result = '0;
    endcase
  end

  // Multiplier next-state and combinational stall request
  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    mul_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_alu_ctrl == OP_MUL && !i_flush) begin
          o_busy     = 1'b1;
          mul_start  = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        o_busy = 1'b1;
        if (i_flush)
          state_next = ST_IDLE;
        else if (iter_cnt == 6'd31)
          state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Multiplier state register
  always_ff @(posedge i_clk) begin
    if (i_reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Shift-add datapath: operands and destination are latched at start so
  // upstream may hold anything while the multiply runs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_prod   <= '0;
      mul_rt     <= '0;
      mul_dest   <= '0;
      mul_ctl    <= '0;
      iter_cnt   <= '0;
    end else if (mul_start) begin
      mul_mcand  <= op_a;
      mul_mplier <= op_b;
      mul_prod   <= '0;
      mul_rt     <= rt_fwd;
      mul_dest   <= dest;
      mul_ctl    <= in_ctl;
      iter_cnt   <= '0;
    end else if (state == ST_BUSY && !i_flush) begin
      if (mul_mplier[0])
        mul_prod <= mul_prod + mul_mcand;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      iter_cnt   <= iter_cnt + 6'd1;
    end
  end

  // EX/MEM register: reset > flush > multiply result/bubble > normal load
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      ex_result <= '0;
      ex_data   <= '0;
      ex_dest   <= '0;
      ex_ctl    <= '0;
    end else if (state == ST_DONE) begin
      ex_result <= mul_prod;
      ex_data   <= mul_rt;
      ex_dest   <= mul_dest;
      ex_ctl    <= mul_ctl;
    end else if (o_busy) begin
      ex_result <= '0;
      ex_data   <= '0;
      ex_dest   <= '0;
      ex_ctl    <= '0;
    end else begin
      ex_result <= alu_result;
      ex_data   <= rt_fwd;
      ex_dest   <= dest;
      ex_ctl    <= in_ctl;
    end
  end

  assign o_ALU_result           = ex_result;
  assign o_data_to_write_in_MEM = ex_data;
  assign o_write_reg            = ex_dest;
  assign {o_WB_write, o_WB_mem_to_reg, o_MEM_read, o_MEM_write,
          o_MEM_unsigned, o_MEM_byte_half_word} = ex_ctl;

endmodule

// File: doc/etapa_ex.md
ETAPA_EX -- requirements
Module: etapa_ex

Interface
REQ-001 Clock and reset: one clock i_clk, rising edge; reset i_reset is synchronous and active-high.
REQ-002 i_clk  in  1  stage clock.
REQ-003 i_reset  in  1  synchronous active-high reset.
REQ-004 i_flush  in  1  squash: next EX/MEM content is a bubble.
REQ-005 i_rs_data, i_rt_data  in  32 each  register-file operands from ID/EX.
REQ-006 i_immediate  in  32  sign/zero-extended immediate.
REQ-007 i_shamt  in  5  shift amount field.
REQ-008 i_rt, i_rd  in  5 each  destination candidates.
REQ-009 i_alu_ctrl  in  4  operation select (REQ-019).
REQ-010 i_alu_src  in  1  1: B = immediate, 0: B = forwarded rt.
REQ-011 i_reg_dst  in  1  1: dest = rd, 0: dest = rt.
REQ-012 i_fwd_a, i_fwd_b  in  2 each  operand source: 00 register, 01 i_fwd_mem_data, 10 i_fwd_wb_data, 11 register.
REQ-013 i_fwd_mem_data, i_fwd_wb_data  in  32 each  forwarded values.
REQ-014 i_WB_write, i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_unsigned  in  1 each; i_MEM_byte_half_word  in  2  control passed to MEM.
REQ-015 o_ALU_result  out  32; o_data_to_write_in_MEM  out  32; o_write_reg  out  5  EX/MEM register contents.
REQ-016 o_WB_write, o_WB_mem_to_reg, o_MEM_read, o_MEM_write, o_MEM_unsigned  out  1 each; o_MEM_byte_half_word  out  2  registered control.
REQ-017 o_busy  out  1  combinational stall request to IF/ID/ID-EX while multiply in progress.

Function
REQ-018 Operand A = forwarded rs per i_fwd_a; forwarded rt per i_fwd_b; B = i_alu_src ? i_immediate : forwarded rt.
REQ-019 i_alu_ctrl: 0 ADD, 1 SUB (both 32-bit wrap, no overflow flag), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU, 8 SLL B by i_shamt, 9 SRL, 10 SRA, 11 SLLV B by A[4:0], 12 SRLV, 13 SRAV, 14 LUI = B<<16, 15 MUL = low 32 bits of A*B (iterative).
REQ-020 SLT/SLTU result is 32'd1 or 32'd0.
REQ-021 Non-MUL ops: result, forwarded rt, dest and all control load into EX/MEM on the next rising edge (latency 1).
REQ-022 o_data_to_write_in_MEM = forwarded rt, never the immediate.
REQ-023 Multiplier FSM states IDLE, BUSY, DONE; 6-bit iteration counter.
REQ-024 IDLE with i_alu_ctrl=15 and no flush: o_busy=1 same cycle; edge latches A, B, dest, control, counter=0, -> BUSY.
REQ-025 BUSY: one shift-add iteration per edge, o_busy=1; after 32nd iteration -> DONE.
REQ-026 DONE: o_busy=0; edge loads product and latched dest/control into EX/MEM, -> IDLE; MUL issued before edge t gives result on outputs after edge t+33.
REQ-027 While o_busy=1, EX/MEM loads a bubble each edge; ID/EX inputs are ignored and held by upstream.
REQ-028 Bubble: all control outputs 0, o_ALU_result, o_data_to_write_in_MEM 0, o_write_reg 0.
REQ-029 i_flush loads a bubble; during BUSY or DONE it aborts the multiply, FSM -> IDLE, o_busy drops next cycle.
REQ-030 Priority: i_reset > i_flush > multiply bubble > normal load.
REQ-031 MUL with any operand zero still takes the full 33 cycles; product wraps mod 2^32.

Reset
REQ-032 Synchronous i_reset=1 at an edge clears all outputs to 0, FSM to IDLE, counter to 0, o_busy=0.
REQ-033 Reset mid-multiply discards the operation; no partial product ever reaches o_ALU_result.

Verification
REQ-034 ADD: rs=5, rt=7, alu_src=0, fwd=00, reg_dst=1, rd=3 -> after 1 edge o_ALU_result=12, o_write_reg=3.
REQ-035 Forwarding: fwd_a=01, i_fwd_mem_data=100, fwd_b=10, i_fwd_wb_data=1, SUB -> o_ALU_result=99; fwd=11 uses rs/rt.
REQ-036 Store path: alu_src=1, imm=8, rt=32'hDEADBEEF, MEM_write=1, byte_half_word=01 -> o_ALU_result=rs+8, o_data_to_write_in_MEM=32'hDEADBEEF, o_MEM_write=1.
REQ-037 Shifts/compare: SRA rt=32'h80000000 shamt=4 -> 32'hF8000000; SLT -1 vs 1 -> 1; SLTU -> 0; LUI imm=16'h1234 -> 32'h12340000.
REQ-038 MUL 32'hFFFF x 32'h10001 -> o_busy high 33 cycles, bubbles meanwhile, then o_ALU_result=32'hFFFFFFFF; MUL with -3 x 7 -> 32'hFFFFFFEB.
REQ-039 Flush and reset mid-multiply at iteration 10 -> bubble on outputs, o_busy=0 next cycle, following ADD completes in 1 cycle.
